ppt_pulse_gen: RTL
==================

# ppt_pulse_gen

Pulse-train generator for the PPT controller, directly downstream of the I2C register map. Consumes the map's `clk_div`, `period`, `width`, `count` and `run_ppt` outputs and drives the thruster firing line `pulse_out`. Returns the firing progress `count_done` and the completion flag `done`, which the register map mirrors back to the I2C side.

## Interface

Parameters:
- `CNT_W`, default 16: width of the period, width and count fields.
- `DIV_W`, default 5: width of the clock-divider exponent.

Ports:
- `clk`, in, 1: single system clock (32.768 kHz oscillator domain).
- `rstn`, in, 1: reset, synchronous and active-low.
- `clk_div`, in, DIV_W: tick exponent. Tick period T = 2^(clk_div+1) clk cycles.
- `period`, in, CNT_W: firing period, in ticks.
- `width`, in, CNT_W: pulse high time, in ticks.
- `count`, in, CNT_W: number of firings to perform.
- `run_ppt`, in, 1: level-sensitive enable.
- `pulse_out`, out, 1: registered thruster firing pulse.
- `count_done`, out, CNT_W: number of firings completed.
- `done`, out, 1: sequence complete.
- `busy`, out, 1: high in PULSE or GAP.

## Operation

- **Reset values:** `pulse_out`=0, `count_done`=0, `done`=0, `busy`=0, state IDLE, prescaler=0.
- **FSM states:** IDLE, PULSE, GAP, DONE.
- **IDLE:**
  - Entered when `run_ppt`=1 is sampled: start.
  - At start, latch `clk_div`, `period`, `width`, `count` into shadow registers. Later input changes are ignored until the next start.
  - At start, clear `count_done` and the prescaler.
  - If latched count = 0, go to DONE. Otherwise go to PULSE.
- **Effective values:**
  - period_eff = max(period, 1).
  - width_eff = min(width, period_eff − 1).
  - Every firing therefore has at least one low tick.
- **PULSE:**
  - `pulse_out`=1.
  - After width_eff ticks, go to GAP.
  - If width_eff = 0, PULSE lasts zero ticks: go straight to GAP, with no high cycle on `pulse_out`.
- **GAP:**
  - `pulse_out`=0.
  - After period_eff − width_eff ticks, the firing ends and `count_done` increments.
  - If the new `count_done` equals the latched count, go to DONE. Otherwise go to PULSE.
- **DONE:**
  - `done`=1 and `count_done` holds.
  - Stay in DONE while `run_ppt`=1.
  - When `run_ppt`=0, go to IDLE and clear `done`. `count_done` retains its value.
- **Abort:** `run_ppt`=0 in PULSE or GAP.
  - Go to IDLE; `pulse_out`=0 on the next cycle.
  - `done` stays 0 and `count_done` retains the partial count.
- **Prescaler:**
  - 32-bit counter; tick when it equals 2^(clk_div+1) − 1, then wrap to 0.
  - Compute with 33-bit arithmetic so that clk_div=31 is legal.
  - Counts only in PULSE/GAP; held at 0 otherwise.
- **Arithmetic:** all tick counters are CNT_W wide and unsigned. `count_done` cannot overflow because it stops at the latched count.

## Timing

- **Start:** `run_ppt` is sampled high at edge N; `pulse_out` rises and `busy` is high from edge N+1.
- **Pulse length:** `pulse_out` is high for exactly width_eff·T cycles.
- **Firing length:** one full firing is exactly period_eff·T cycles. Consecutive firings are back-to-back with no idle cycles.
- **Completion:** `count_done` updates in the same cycle as the PULSE/GAP transition that ends each firing. On the final firing, `done` rises in the same cycle that `count_done` reaches the latched count.
- **count = 0:** `done` rises at N+1; `pulse_out` is never asserted.
- **Stop from DONE:** `run_ppt` sampled low at edge M; `done` = 0 from M+1.
- **Reset priority:** `rstn`=0 overrides everything at the next edge, including mid-pulse; all outputs return to their reset values.

## Structure

- **Package `ppt_pkg`:**
  - state enum (IDLE, PULSE, GAP, DONE)
  - `CNT_W`, `DIV_W`
  - a function computing the prescaler terminal value from `clk_div`
- **Sub-module `ppt_prescaler`:** inputs `clk`, `rstn`, `en`, `clk_div`; output `tick`. Contains the 32-bit counter.
- **Top level:** FSM, tick counter, firing counter and shadow registers.

## Test plan

- **Basic train:** clk_div=0 (T=2), period=4, width=1, count=3, `run_ppt` raised.
  - Expect three pulses, each 2 cycles high then 6 low.
  - Expect `count_done` to step 1, 2, 3, and `done`=1 exactly 24 cycles after `pulse_out` first rises.
- **Clamping:**
  - width=0, period=3, count=2: `pulse_out` never asserts; `done` after 12 cycles (T=2).
  - width=9, period=4: pulse is 3 ticks high, 1 tick low.
- **count=0:** `done`=1 one cycle after start, `pulse_out` stays 0, `count_done`=0.
- **Abort and restart:**
  - Drop `run_ppt` during the second pulse: `pulse_out`=0 next cycle, `count_done`=1, `done`=0.
  - Re-raise `run_ppt`: `count_done` clears to 0 and a full new train runs.
- **Latching:** change `period` and `width` mid-train; the timing of the running train is unchanged. Then drop and re-raise `run_ppt`: the new values take effect.
- **Reset and divider:**
  - Assert `rstn`=0 mid-pulse: all outputs are 0 at the next edge.
  - Then run clk_div=9: tick every 1024 cycles, and period=128 gives 131072 cycles per firing.

Source files
------------

// File: rtl/ppt_pkg.sv
// Shared types and helpers for the PPT pulse-train generator.
package ppt_pkg;

    localparam int CNT_W = 16;
    localparam int DIV_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Terminal count 2^(div+1)-1; 33-bit so div=31 yields all ones.
    function automatic logic [31:0] presc_term(input logic [31:0] div);
        logic [32:0] pow;
        logic [32:0] term;
        pow  = 33'd1 << (div + 32'd1);
        term = pow - 33'd1;
        return term[31:0];
    endfunction

endpackage

// File: rtl/ppt_prescaler.sv
// Tick generator: one tick every 2^(clk_div+1) enabled cycles.
module ppt_prescaler #(
    parameter int DIV_W = ppt_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);
    import ppt_pkg::*;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] term;

    always_comb begin
        term = presc_term(32'(clk_div));
        tick = en && (cnt_q == term);
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ppt_pulse_gen.sv
// PPT firing sequencer: latches the register-map settings at start and
// emits count pulses of width_eff ticks every period_eff ticks.
module ppt_pulse_gen #(
    parameter int CNT_W = ppt_pkg::CNT_W,
    parameter int DIV_W = ppt_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic             pulse_out,
    output logic [CNT_W-1:0] count_done,
    output logic             done,
    output logic             busy
);
    import ppt_pkg::*;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tck_q, tck_d;
    logic [CNT_W-1:0] cdone_q, cdone_d;
    logic             pulse_q, pulse_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] per_eff;
    logic [CNT_W-1:0] wid_eff;
    logic [CNT_W-1:0] tck_nx;
    logic [CNT_W-1:0] cdone_nx;
    logic             run_en;
    logic             tick;

    assign run_en = (state_q == S_PULSE) || (state_q == S_GAP);

    ppt_prescaler #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk     (clk),
        .rstn    (rstn),
        .en      (run_en),
        .clk_div (div_q),
        .tick    (tick)
    );

    // Clamp so every firing keeps at least one low tick.
    always_comb begin
        per_eff = (period == '0) ? CNT_W'(1) : period;
        wid_eff = (width >= per_eff) ? (per_eff - CNT_W'(1)) : width;
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        wid_d    = wid_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        tck_d    = tck_q;
        cdone_d  = cdone_q;
        pulse_d  = pulse_q;
        done_d   = done_q;
        busy_d   = busy_q;
        tck_nx   = tck_q + CNT_W'(1);
        cdone_nx = cdone_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                if (run_ppt) begin
                    div_d   = clk_div;
                    wid_d   = wid_eff;
                    gap_d   = per_eff - wid_eff;
                    cnt_d   = count;
                    cdone_d = '0;
                    tck_d   = '0;
                    if (count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = (wid_eff == '0) ? S_GAP : S_PULSE;
                        pulse_d = (wid_eff != '0);
                        busy_d  = 1'b1;
                    end
                end
            end
            S_PULSE: begin
                if (!run_ppt) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    tck_d   = '0;
                end else if (tick) begin
                    if (tck_nx == wid_q) begin
                        state_d = S_GAP;
                        pulse_d = 1'b0;
                        tck_d   = '0;
                    end else begin
                        tck_d = tck_nx;
                    end
                end
            end
            S_GAP: begin
                if (!run_ppt) begin
                    state_d = S_IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    tck_d   = '0;
                end else if (tick) begin
                    if (tck_nx == gap_q) begin
                        cdone_d = cdone_nx;
                        tck_d   = '0;
                        if (cdone_nx == cnt_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            pulse_d = 1'b0;
                        end else begin
                            state_d = (wid_q == '0) ? S_GAP : S_PULSE;
                            pulse_d = (wid_q != '0);
                        end
                    end else begin
                        tck_d = tck_nx;
                    end
                end
            end
            S_DONE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                if (!run_ppt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            wid_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            tck_q   <= '0;
            cdone_q <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wid_q   <= wid_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            tck_q   <= tck_d;
            cdone_q <= cdone_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign count_done = cdone_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule
